// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter; the hazard unit also uses
// the grant constants to steer its stall muxing.
package mem_port_arbiter_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] grant_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t GNT_I = 2'd1;
    localparam state_t GNT_D = 2'd2;

    localparam grant_t GRANT_NONE = 2'b00;
    localparam grant_t GRANT_I    = 2'b01;
    localparam grant_t GRANT_D    = 2'b10;

    function automatic state_t grant_to_state(input grant_t g);
        case (g)
            GRANT_I: return GNT_I;
            GRANT_D: return GNT_D;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick2.sv
// Two-way pick between fetch and data: data normally wins, but fetch wins
// whenever the previous grant went to data, so IF can never be starved.
module arb_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  logic   last_d,
    output grant_t grant
);

    always_comb begin
        grant = GRANT_NONE;
        if (if_req && (last_d || !d_req)) begin
            grant = GRANT_I;
        end else if (d_req) begin
            grant = GRANT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and MEM-stage
// loads/stores, with per-requester stalls and a sticky bus timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    output logic                if_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_done,
    output logic                d_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                bus_err
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(BE_W - 1);

    state_t            state;
    grant_t            grant;
    logic              last_d;
    logic              flushed;
    logic [7:0]        wait_cnt;
    logic [7:0]        cnt_next;
    logic              timeout_hit;
    logic [DATA_W-1:0] done_data;

    // The requester that is completing this cycle is masked so it cannot be
    // re-granted off the request level it held for the finished transaction.
    arb_pick2 u_pick (
        .if_req (if_req & ~if_done),
        .d_req  (d_req & ~d_done),
        .last_d (last_d),
        .grant  (grant)
    );

    assign cnt_next    = wait_cnt + 8'd1;
    assign timeout_hit = (cnt_next == 8'(TIMEOUT));
    assign done_data   = mem_ack ? mem_rdata : '0;
    assign mem_req     = (state != IDLE);
    assign if_stall    = if_req & ~if_done;
    assign d_stall     = d_req & ~d_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            flushed   <= 1'b0;
            wait_cnt  <= '0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant != GRANT_NONE) begin
                        state    <= grant_to_state(grant);
                        wait_cnt <= '0;
                        flushed  <= 1'b0;
                        last_d   <= (grant == GRANT_D);
                        if (grant == GRANT_D) begin
                            mem_addr  <= d_addr & ~ADDR_MASK;
                            mem_we    <= d_we;
                            mem_be    <= d_we ? d_be : '1;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_addr  <= if_addr & ~ADDR_MASK;
                            mem_we    <= 1'b0;
                            mem_be    <= '1;
                            mem_wdata <= '0;
                        end
                    end
                end
                GNT_I, GNT_D: begin
                    wait_cnt <= cnt_next;
                    // A fetch withdrawn even once (branch flush) must not see its done.
                    if (state == GNT_I && !if_req) begin
                        flushed <= 1'b1;
                    end
                    if (mem_ack || timeout_hit) begin
                        state <= IDLE;
                        if (!mem_ack) begin
                            bus_err <= 1'b1;
                        end
                        if (state == GNT_D) begin
                            d_done  <= 1'b1;
                            d_rdata <= done_data;
                        end else if (!flushed && if_req) begin
                            if_done  <= 1'b1;
                            if_rdata <= done_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by randomized traffic checked against a
// transaction-level model of the arbiter and a byte-addressed memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        bus_err;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_stall  (if_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .d_stall   (d_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    // Reference memory: word address -> contents, with a fixed fill pattern.
    logic [31:0] mem_model [logic [31:0]];

    // Transaction-level model state for the randomized phase.
    bit          m_last_d;
    bit          m_busy;
    bit          p_busy;
    bit          p_acked;
    bit          p_el_i;
    bit          p_el_d;
    bit          cur_d;
    int          cur_wait;
    int          cur_delay;
    bit          exp_i_done;
    bit          exp_d_done;
    logic [31:0] exp_rdata;
    int          served;
    int          issued_i;
    int          issued_d;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic dwe, input logic [3:0] dbe,
                                 input logic [31:0] daddr, input logic [31:0] dwdata);
        if_req  = ireq;
        if_addr = iaddr;
        d_req   = dreq;
        d_we    = dwe;
        d_be    = dbe;
        d_addr  = daddr;
        d_wdata = dwdata;
    endtask

    // Waits for the next memory request (expected one cycle after the grant
    // cycle we are in), checks the bus fields, acks immediately, checks done.
    task automatic serveOne(input string tag, input bit exp_d, input logic [31:0] exp_addr,
                            input logic exp_we, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] rdata);
        int waited = 0;
        while (!mem_req && waited < 10) begin
            tick();
            waited++;
        end
        checkOutput({tag, "_wait"}, 32'(waited), 1);
        checkOutput({tag, "_addr"}, mem_addr, exp_addr);
        checkOutput({tag, "_we"}, 32'(mem_we), 32'(exp_we));
        checkOutput({tag, "_be"}, 32'(mem_be), 32'(exp_be));
        if (exp_we) checkOutput({tag, "_wdata"}, mem_wdata, exp_wdata);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        checkOutput({tag, "_done"}, 32'(exp_d ? d_done : if_done), 1);
        checkOutput({tag, "_other_done"}, 32'(exp_d ? if_done : d_done), 0);
        checkOutput({tag, "_rdata"}, exp_d ? d_rdata : if_rdata, rdata);
    endtask

    initial begin
        int gnt_cycles;
        logic [31:0] waddr;
        logic [31:0] w;
        bit busy_now;
        bit acked;
        bit done_i_now;
        bit done_d_now;

        // Reset held with a fetch pending: nothing may reach the bus.
        rst = 1'b0;
        applyStimulus(1, 32'h103, 0, 0, 4'h0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("reset_mem_req", 32'(mem_req), 0);
            checkOutput("reset_if_done", 32'(if_done), 0);
            checkOutput("reset_d_done", 32'(d_done), 0);
            checkOutput("reset_bus_err", 32'(bus_err), 0);
        end
        checkOutput("reset_if_rdata", if_rdata, 0);
        rst = 1'b1;

        // Lone fetch from an unaligned address.
        serveOne("fetch", 0, 32'h100, 0, 4'hF, 0, 32'hCAFE_0001);
        checkOutput("fetch_stall_in_done", 32'(if_stall), 0);
        applyStimulus(0, 0, 0, 0, 4'h0, 0, 0);

        // Ack without a request must be ignored.
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        checkOutput("spurious_mem_req", 32'(mem_req), 0);
        checkOutput("spurious_if_done", 32'(if_done), 0);
        checkOutput("spurious_d_done", 32'(d_done), 0);

        // Contention: D first, then alternation D,I,D,I while both keep asking.
        applyStimulus(1, 32'h200, 1, 0, 4'h0, 32'h304, 0);
        serveOne("cont_d1", 1, 32'h304, 0, 4'hF, 0, 32'h0000_00D1);
        d_addr = 32'h308;
        serveOne("cont_i1", 0, 32'h200, 0, 4'hF, 0, 32'h0000_00A1);
        if_addr = 32'h204;
        serveOne("cont_d2", 1, 32'h308, 0, 4'hF, 0, 32'h0000_00D2);
        d_addr = 32'h30C;
        serveOne("cont_i2", 0, 32'h204, 0, 4'hF, 0, 32'h0000_00A2);
        if_req = 1'b0;
        serveOne("cont_d3", 1, 32'h30C, 0, 4'hF, 0, 32'h0000_00D3);
        d_req = 1'b0;
        tick();

        // Partial store.
        applyStimulus(0, 0, 1, 1, 4'b0011, 32'h40, 32'hDEAD_BEEF);
        serveOne("store", 1, 32'h40, 1, 4'b0011, 32'hDEAD_BEEF, 32'h0BAD_0BAD);
        applyStimulus(0, 0, 0, 0, 4'h0, 0, 0);
        tick();

        // Flush: fetch withdrawn mid-transaction, data waiting behind it.
        applyStimulus(1, 32'h500, 0, 0, 4'h0, 0, 0);
        tick();
        checkOutput("flush_mem_req", 32'(mem_req), 1);
        checkOutput("flush_mem_addr", mem_addr, 32'h500);
        applyStimulus(0, 0, 1, 0, 4'h0, 32'h600, 0);
        tick();
        checkOutput("flush_hold_req", 32'(mem_req), 1);
        checkOutput("flush_hold_addr", mem_addr, 32'h500);
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_5555;
        tick();
        mem_ack = 1'b0;
        checkOutput("flush_no_if_done", 32'(if_done), 0);
        checkOutput("flush_no_d_done", 32'(d_done), 0);
        serveOne("after_flush", 1, 32'h600, 0, 4'hF, 0, 32'h0000_0600);
        applyStimulus(0, 0, 0, 0, 4'h0, 0, 0);
        tick();

        // Timeout: never ack a load.
        applyStimulus(0, 0, 1, 0, 4'h0, 32'h700, 0);
        gnt_cycles = 0;
        tick();
        while (mem_req && gnt_cycles < 20) begin
            gnt_cycles++;
            tick();
        end
        checkOutput("timeout_gnt_cycles", 32'(gnt_cycles), 4);
        checkOutput("timeout_bus_err", 32'(bus_err), 1);
        checkOutput("timeout_d_done", 32'(d_done), 1);
        checkOutput("timeout_d_rdata", d_rdata, 0);
        d_req = 1'b0;
        tick();
        checkOutput("timeout_sticky", 32'(bus_err), 1);
        checkOutput("timeout_done_pulse", 32'(d_done), 0);

        // Reset in the middle of a grant.
        applyStimulus(0, 0, 1, 0, 4'h0, 32'h800, 0);
        tick();
        checkOutput("midrst_req_before", 32'(mem_req), 1);
        rst = 1'b0;
        tick();
        checkOutput("midrst_mem_req", 32'(mem_req), 0);
        checkOutput("midrst_bus_err", 32'(bus_err), 0);
        checkOutput("midrst_d_rdata", d_rdata, 0);
        checkOutput("midrst_if_rdata", if_rdata, 0);
        applyStimulus(0, 0, 0, 0, 4'h0, 0, 0);
        rst = 1'b1;
        tick();
        checkOutput("midrst_no_done", 32'(d_done), 0);

        // Randomized traffic from a clean reset.
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        m_last_d = 0; m_busy = 0; p_busy = 0; p_acked = 0;
        p_el_i = 0; p_el_d = 0; exp_i_done = 0; exp_d_done = 0;
        served = 0; issued_i = 0; issued_d = 0;
        for (int cyc = 0; cyc < 4000 && served < 80; cyc++) begin
            tick();
            checkOutput("rnd_if_done", 32'(if_done), 32'(exp_i_done));
            checkOutput("rnd_d_done", 32'(d_done), 32'(exp_d_done));
            if (exp_i_done) checkOutput("rnd_if_rdata", if_rdata, exp_rdata);
            if (exp_d_done) checkOutput("rnd_d_rdata", d_rdata, exp_rdata);
            checkOutput("rnd_if_stall", 32'(if_stall), 32'(if_req & ~exp_i_done));
            checkOutput("rnd_d_stall", 32'(d_stall), 32'(d_req & ~exp_d_done));
            done_i_now = exp_i_done;
            done_d_now = exp_d_done;
            if (done_i_now) begin if_req = 1'b0; served++; end
            if (done_d_now) begin d_req = 1'b0; served++; end
            exp_i_done = 0;
            exp_d_done = 0;

            // Grant decision made in the previous (idle) cycle shows up now.
            if (!p_busy) begin
                checkOutput("rnd_grant", 32'(mem_req), 32'(p_el_i | p_el_d));
                if (p_el_i | p_el_d) begin
                    cur_d     = p_el_d && !(m_last_d && p_el_i);
                    m_last_d  = cur_d;
                    m_busy    = 1;
                    cur_wait  = 0;
                    cur_delay = $urandom_range(0, 2);
                    if (cur_d) begin
                        checkOutput("rnd_d_addr", mem_addr, d_addr & ~32'h3);
                        checkOutput("rnd_d_we", 32'(mem_we), 32'(d_we));
                        checkOutput("rnd_d_be", 32'(mem_be), d_we ? 32'(d_be) : 32'hF);
                        if (d_we) checkOutput("rnd_d_wdata", mem_wdata, d_wdata);
                    end else begin
                        checkOutput("rnd_i_addr", mem_addr, if_addr & ~32'h3);
                        checkOutput("rnd_i_we", 32'(mem_we), 0);
                        checkOutput("rnd_i_be", 32'(mem_be), 32'hF);
                    end
                end
            end else if (p_acked) begin
                checkOutput("rnd_idle_after_ack", 32'(mem_req), 0);
            end else begin
                checkOutput("rnd_hold", 32'(mem_req), 1);
            end

            // Memory responder.
            busy_now = m_busy;
            acked    = 0;
            if (m_busy) begin
                if (cur_wait == cur_delay) begin
                    acked   = 1;
                    mem_ack = 1'b1;
                    waddr   = cur_d ? (d_addr & ~32'h3) : (if_addr & ~32'h3);
                    if (cur_d && d_we) begin
                        mem_rdata = $urandom;
                        w = memWord(waddr);
                        for (int b = 0; b < 4; b++)
                            if (d_be[b]) w[8*b +: 8] = d_wdata[8*b +: 8];
                        mem_model[waddr] = w;
                    end else begin
                        mem_rdata = memWord(waddr);
                    end
                    exp_rdata  = mem_rdata;
                    exp_i_done = !cur_d;
                    exp_d_done = cur_d;
                    m_busy     = 0;
                end else begin
                    mem_ack = 1'b0;
                    cur_wait++;
                end
            end else begin
                mem_ack   = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end

            // Requesters issue a new access once their previous one is done.
            if (!if_req && issued_i < 40 && $urandom_range(0, 2) != 0) begin
                if_req  = 1'b1;
                if_addr = 32'($urandom_range(0, 63));
                issued_i++;
            end
            if (!d_req && issued_d < 40 && $urandom_range(0, 2) != 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_be    = 4'($urandom_range(1, 15));
                d_addr  = 32'($urandom_range(0, 63));
                d_wdata = $urandom;
                issued_d++;
            end
            p_el_i  = if_req && !done_i_now;
            p_el_d  = d_req && !done_d_now;
            p_busy  = busy_now;
            p_acked = acked;
        end
        checkOutput("rnd_served", 32'(served), 80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
